mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 64, number of storage words.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH) (6), address width in bits.
REQ-004 Parameter WAIT_CYCLES, default 2, wait states inserted before ready_o; legal range 0..15.
REQ-005 clk_i  input  1  sole clock; all state updates on posedge.
REQ-006 rst_i  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 valid_i  input  1  initiator request valid; held high until the transfer completes.
REQ-008 wr_rd_i  input  1  1 = write, 0 = read.
REQ-009 addr_i  input  ADDR_WIDTH  word address.
REQ-010 wr_data_i  input  WIDTH  write data.
REQ-011 rd_data_o  output  WIDTH  read data, registered.
REQ-012 ready_o  output  1  transfer-complete strobe, registered.

Function
REQ-013 The block SHALL hold DEPTH x WIDTH storage and act as the responder end of the valid/ready memory protocol.
REQ-014 FSM states SHALL be IDLE, WAIT, and RESP, with reset state IDLE.
REQ-015 In IDLE with valid_i=1 at edge N, the block SHALL latch wr_rd_i, addr_i, and wr_data_i. It SHALL load wait counter = WAIT_CYCLES and go to WAIT, or go directly to RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, the counter SHALL decrement every edge; when it reaches 1 and is decremented, the FSM SHALL move to RESP.
REQ-017 ready_o SHALL be 1 only in RESP and SHALL last exactly one cycle: high after edge N+1+WAIT_CYCLES, low after the following edge.
REQ-018 The transfer SHALL complete at the edge where valid_i=1 and ready_o=1. The FSM then SHALL return to IDLE.
REQ-019 A write SHALL update storage[latched addr] with the latched data at the completing edge; rd_data_o SHALL be unchanged by a write.
REQ-020 A read SHALL drive rd_data_o = storage[latched addr] on the same cycle ready_o is high. rd_data_o SHALL hold that value until the next read completes.
REQ-021 Read-after-write to the same address SHALL return the newly written data.
REQ-022 If valid_i=0 in WAIT or RESP (initiator abort), the FSM SHALL return to IDLE at that edge with no storage update and no rd_data_o change.
REQ-023 After any completion or abort, ready_o SHALL be low for at least one cycle; a new request SHALL be accepted no earlier than the edge after returning to IDLE.
REQ-024 Changes on addr_i, wr_data_i, or wr_rd_i after acceptance SHALL be ignored; the latched values govern the transfer.

Reset
REQ-025 rst_i=0 SHALL immediately force state=IDLE, ready_o=0, rd_data_o=0, wait counter=0, and all storage words=0, independent of clk_i.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no storage write; the first request after deassertion SHALL be handled normally.

Structure
REQ-027 A shared package SHALL hold the WIDTH/DEPTH/ADDR_WIDTH defaults and the FSM state enum, and SHALL be shared with the interface and bench.
REQ-028 The design SHALL be one module with no sub-modules; storage SHALL be an internal register array.

Verification
REQ-029 Reset then read addr 5 -> ready_o pulses at edge N+3 (WAIT_CYCLES=2); rd_data_o=16'h0000.
REQ-030 Write 16'hBEEF to addr 10, then read addr 10 -> single-cycle ready_o for each transfer; read returns 16'hBEEF.
REQ-031 Write addr 63=16'h1234 and addr 0=16'hABCD, then read both -> 16'h1234 and 16'hABCD (address bounds).
REQ-032 Write 16'h5555 to addr 7, dropping valid_i during WAIT -> FSM returns to IDLE and ready_o never rises; a later read of addr 7 returns 16'h0000.
REQ-033 Assert rst_i=0 in WAIT of a write 16'hFFFF to addr 3 -> ready_o=0 immediately; a later read of addr 3 returns 16'h0000.
REQ-034 WAIT_CYCLES=0, back-to-back writes -> ready_o high one cycle after each acceptance, with at least one low cycle between pulses.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and its bench.
//   DEF_WIDTH / DEF_DEPTH / DEF_ADDR_WIDTH / DEF_WAIT_CYCLES : parameter defaults
//   WAIT_CNT_W : width of the wait-state counter (0..15 wait states)
//   state_t    : responder FSM state encoding (IDLE, WAIT, RESP)
package mem_responder_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_ADDR_WIDTH  = $clog2(DEF_DEPTH);
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder.sv
// Responder end of a valid/ready memory protocol with DEPTH x WIDTH storage.
//
// Handshake: the initiator raises valid_i with wr_rd_i/addr_i/wr_data_i and
// holds valid_i high until it has seen ready_o. The request is latched on the
// first edge in IDLE with valid_i high; later changes on the request lines are
// ignored. After WAIT_CYCLES wait states ready_o pulses for exactly one cycle,
// and the transfer completes on the edge where valid_i and ready_o are both
// high. Dropping valid_i before completion aborts the transfer: nothing is
// written and rd_data_o keeps its value.
//
// Ports:
//   clk_i      clock, all state changes on posedge
//   rst_i      asynchronous active-low reset; clears FSM, outputs and storage
//   valid_i    request valid
//   wr_rd_i    1 = write, 0 = read
//   addr_i     word address
//   wr_data_i  write data
//   rd_data_o  registered read data, held until the next read returns data
//   ready_o    registered one-cycle transfer-complete strobe
//   state_o    current FSM state (debug visibility)
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  ready_o,
    output logic [1:0]            state_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    ready_d;
    logic                    accept;
    logic                    complete;

    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WIDTH-1:0]        data_q;
    logic [WIDTH-1:0]        mem_q [DEPTH];

    assign state_o = state_q;

    // RESP spans two cycles: the first raises ready_o, the second (ready_o
    // high) is where the initiator completes the transfer. This keeps ready_o
    // registered and confined to RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!valid_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (!valid_i) begin
                    state_d = ST_IDLE;
                end else if (ready_o) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_o <= ready_d;
        end
    end

    // Read data is captured on the edge that raises ready_o so it is valid
    // for the whole strobe cycle; writes land on the completing edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                wr_q   <= wr_rd_i;
                addr_q <= addr_i;
                data_q <= wr_data_i;
            end
            if (complete && wr_q) begin
                mem_q[addr_q] <= data_q;
            end
            if (ready_d && !wr_q) begin
                rd_data_o <= mem_q[addr_q];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states and 0 wait states)
// share request lines but have separate valid_i. Drivers push the expected
// response (ready cycle, read data from a behavioural memory model) into a
// per-instance queue; a negedge monitor pops on every ready_o and also checks
// that rd_data_o always holds the most recently returned read value.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int W   = DEF_WIDTH;
    localparam int A   = DEF_ADDR_WIDTH;
    localparam int D   = DEF_DEPTH;
    localparam int WC0 = 2;
    localparam int WC1 = 0;

    typedef struct {
        logic         is_rd;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid0 = 1'b0;
    logic         valid1 = 1'b0;
    logic         wr_rd = 1'b0;
    logic [A-1:0] addr = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rd0, rd1;
    logic         ready0, ready1;
    logic [1:0]   state0, state1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t         exp_q0[$];
    exp_t         exp_q1[$];
    logic [W-1:0] model_mem [2][D];
    logic [W-1:0] last_rd [2];
    logic         prev_rdy [2];

    mem_responder #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A), .WAIT_CYCLES(WC0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid0), .wr_rd_i(wr_rd),
        .addr_i(addr), .wr_data_i(wdata), .rd_data_o(rd0), .ready_o(ready0),
        .state_o(state0)
    );

    mem_responder #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A), .WAIT_CYCLES(WC1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid1), .wr_rd_i(wr_rd),
        .addr_i(addr), .wr_data_i(wdata), .rd_data_o(rd1), .ready_o(ready1),
        .state_o(state1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic rdy(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    function automatic int wc(input int d);
        return (d == 0) ? WC0 : WC1;
    endfunction

    task automatic set_valid(input int d, input logic v);
        if (d == 0) valid0 = v;
        else        valid1 = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < D; i++) model_mem[d][i] = '0;
            last_rd[d]  = '0;
            prev_rdy[d] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // ---------------- driver tasks (called at a negedge, DUT idle next edge) ----------------
    task automatic xfer(input int d, input logic wr, input logic [A-1:0] a, input logic [W-1:0] dat);
        exp_t e;
        int   t;
        // Acceptance edge is cyc+1; ready_o is seen at the negedge after
        // edge (acceptance + 1 + wait states).
        e.is_rd = !wr;
        e.data  = wr ? '0 : model_mem[d][a];
        e.cyc   = cyc + 2 + wc(d);
        if (wr) model_mem[d][a] = dat;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        wr_rd = wr;
        addr  = a;
        wdata = dat;
        set_valid(d, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        // Request lines are don't-care once accepted.
        wr_rd = 1'($urandom);
        addr  = A'($urandom);
        wdata = W'($urandom);
        t = 0;
        while (!rdy(d) && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 40) begin
            failures++;
            checks++;
            $display("FAIL ready_timeout: dut%0d no ready_o within 40 cycles", d);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        set_valid(d, 1'b0);
    endtask

    // Drop valid_i k cycles after acceptance, before ready_o can rise.
    task automatic abort_xfer(input int d, input logic wr, input logic [A-1:0] a,
                              input logic [W-1:0] dat, input int k);
        wr_rd = wr;
        addr  = a;
        wdata = dat;
        set_valid(d, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        repeat (k) @(negedge clk_i);
        set_valid(d, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        check($sformatf("abort_idle_dut%0d", d), 32'((d == 0) ? state0 : state1), 32'(ST_IDLE));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t         e;
        logic         r;
        logic [W-1:0] rdv;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                for (int d = 0; d < 2; d++) begin
                    r   = rdy(d);
                    rdv = (d == 0) ? rd0 : rd1;
                    if (r) begin
                        check($sformatf("ready_width_dut%0d", d), 32'(prev_rdy[d]), 32'd0);
                        if (((d == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_ready: dut%0d ready_o=1 with no transfer pending at cycle %0d", d, cyc);
                        end else begin
                            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
                            if (e.is_rd) last_rd[d] = e.data;
                        end
                    end
                    check($sformatf("rd_data_dut%0d", d), 32'(rdv), 32'(last_rd[d]));
                    prev_rdy[d] = r;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int op;
        logic [A-1:0] a;
        model_reset();
        idle(3);
        check("reset_ready0", 32'(ready0), 32'd0);
        check("reset_ready1", 32'(ready1), 32'd0);
        check("reset_rd0",    32'(rd0),    32'd0);
        check("reset_rd1",    32'(rd1),    32'd0);
        check("reset_state0", 32'(state0), 32'(ST_IDLE));
        check("reset_state1", 32'(state1), 32'(ST_IDLE));
        rst_i = 1'b1;
        idle(2);

        // Directed cases on the 2-wait-state instance.
        xfer(0, 1'b0, 6'd5, '0);
        idle(1);
        xfer(0, 1'b1, 6'd10, 16'hBEEF);
        xfer(0, 1'b0, 6'd10, '0);
        xfer(0, 1'b1, 6'd63, 16'h1234);
        xfer(0, 1'b1, 6'd0, 16'hABCD);
        xfer(0, 1'b0, 6'd63, '0);
        xfer(0, 1'b0, 6'd0, '0);
        abort_xfer(0, 1'b1, 6'd7, 16'h5555, 1);
        idle(4);
        xfer(0, 1'b0, 6'd7, '0);

        // Reset in WAIT of a write; the earlier write to addr 3 must be wiped too.
        xfer(0, 1'b1, 6'd3, 16'h1111);
        wr_rd = 1'b1;
        addr  = 6'd3;
        wdata = 16'hFFFF;
        valid0 = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        valid0 = 1'b0;
        #1;
        check("rst_mid_ready0", 32'(ready0), 32'd0);
        check("rst_mid_state0", 32'(state0), 32'(ST_IDLE));
        check("rst_mid_rd0",    32'(rd0),    32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(1);
        xfer(0, 1'b0, 6'd3, '0);
        xfer(0, 1'b0, 6'd10, '0);

        // Randomized traffic, biased toward a few addresses for read-after-write.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 3) == 0) ? A'($urandom_range(0, D - 1)) : A'($urandom_range(0, 7));
            if (op == 0) abort_xfer(0, 1'($urandom), a, W'($urandom), $urandom_range(0, 2));
            else         xfer(0, op < 5, a, W'($urandom));
            idle($urandom_range(0, 2));
        end

        // Zero-wait-state instance: back-to-back writes, reads, aborts.
        for (int i = 0; i < 8; i++) begin
            xfer(1, 1'b1, A'(i), W'($urandom));
        end
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            a  = A'($urandom_range(0, 11));
            if (op == 0) abort_xfer(1, 1'b1, a, W'($urandom), 0);
            else         xfer(1, op < 4, a, W'($urandom));
            if ($urandom_range(0, 1) == 0) idle(1);
        end

        idle(5);
        check("drain_q0", 32'(exp_q0.size()), 32'd0);
        check("drain_q1", 32'(exp_q1.size()), 32'd0);
        check("final_state0", 32'(state0), 32'(ST_IDLE));
        check("final_state1", 32'(state1), 32'(ST_IDLE));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
